// File: rtl/itch_message_encoder_if.sv
// itch_message_encoder_if: command fields and byte-stream bundle for the ITCH encoder
interface itch_message_encoder_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_type;
   logic [15:0] cmd_locate;
   logic [15:0] cmd_tracking;
   logic [47:0] cmd_timestamp;
   logic [63:0] cmd_order_ref;
   logic [63:0] cmd_new_ref;
   logic        cmd_buy_sell;
   logic [31:0] cmd_shares;
   logic [31:0] cmd_price;
   logic [63:0] cmd_stock;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_byte;
   logic        out_start;
   logic        out_end;
   logic        err_bad_type;
   logic [31:0] msg_count;
   modport master (
      input  cmd_valid, cmd_type, cmd_locate, cmd_tracking, cmd_timestamp, cmd_order_ref,
             cmd_new_ref, cmd_buy_sell, cmd_shares, cmd_price, cmd_stock, out_ready,
      output cmd_ready, out_valid, out_byte, out_start, out_end, err_bad_type, msg_count
   );
   modport slave (
      output cmd_valid, cmd_type, cmd_locate, cmd_tracking, cmd_timestamp, cmd_order_ref,
             cmd_new_ref, cmd_buy_sell, cmd_shares, cmd_price, cmd_stock, out_ready,
      input  cmd_ready, out_valid, out_byte, out_start, out_end, err_bad_type, msg_count
   );
endinterface

// File: rtl/itch_message_encoder.sv
// itch_message_encoder: serializes an order-event command into a big-endian ITCH 5.0 byte stream
module itch_message_encoder #(
   parameter bit EMIT_LEN_PREFIX = 1'b0
) (
   input logic                    clk,
   input logic                    rst_n,
   itch_message_encoder_if.master bus
);
   typedef enum logic [1:0] {IDLE, LEN_HI, LEN_LO, BODY} state_t;
   state_t       state_q, state_d;
   logic [287:0] sr_q, sr_d, img;
   logic [87:0]  hdr;
   logic [5:0]   cnt_q, cnt_d, len_q, len_d, len_sel;
   logic [31:0]  msg_count_q, msg_count_d;
   logic         ready_q, first_q, first_d, valid_q, valid_d, err_q, err_d;
   logic         supported, accept, load, fire, last;
   // Build the left-aligned body image and its length from the live command fields
   always_comb begin
      hdr       = {bus.cmd_type, bus.cmd_locate, bus.cmd_tracking, bus.cmd_timestamp};
      supported = 1'b1;
      len_sel   = 6'd36;
      img       = {hdr, bus.cmd_order_ref, bus.cmd_buy_sell ? 8'h42 : 8'h53,
                   bus.cmd_shares, bus.cmd_stock, bus.cmd_price};
      case (bus.cmd_type)
         8'h41: ;
         8'h58: begin
            len_sel = 6'd23;
            img     = {hdr, bus.cmd_order_ref, bus.cmd_shares, 104'h0};
         end
         8'h44: begin
            len_sel = 6'd19;
            img     = {hdr, bus.cmd_order_ref, 136'h0};
         end
         8'h55: begin
            len_sel = 6'd35;
            img     = {hdr, bus.cmd_order_ref, bus.cmd_new_ref, bus.cmd_shares, bus.cmd_price, 8'h0};
         end
         default: supported = 1'b0;
      endcase
   end
   assign accept = bus.cmd_valid && bus.cmd_ready;
   assign load   = accept && supported;
   assign fire   = valid_q && bus.out_ready;
   assign last   = state_q == BODY && cnt_q == 6'd1;
   // State and datapath registers; reset abandons any partial message
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         msg_count_q <= '0;
         ready_q     <= 1'b0;
         first_q     <= 1'b0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         msg_count_q <= msg_count_d;
         ready_q     <= 1'b1;
         first_q     <= first_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end
   // Next state: header bytes and body bytes advance only on an accepted byte
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = load ? (EMIT_LEN_PREFIX ? LEN_HI : BODY) : IDLE;
         LEN_HI:  state_d = fire ? LEN_LO : LEN_HI;
         LEN_LO:  state_d = fire ? BODY : LEN_LO;
         default: state_d = fire && last ? IDLE : BODY;
      endcase
   end
   // Datapath next values and stream outputs
   always_comb begin
      sr_d        = load ? img : (fire && state_q == BODY) ? {sr_q[279:0], 8'h00} : sr_q;
      cnt_d       = load ? len_sel : (fire && state_q == BODY) ? cnt_q - 6'd1 : cnt_q;
      len_d       = load ? len_sel : len_q;
      first_d     = load ? 1'b1 : fire ? 1'b0 : first_q;
      valid_d     = state_d != IDLE;
      err_d       = accept && !supported;
      msg_count_d = fire && last ? msg_count_q + 32'd1 : msg_count_q;
   end
   assign bus.cmd_ready    = ready_q && state_q == IDLE;
   assign bus.out_valid    = valid_q;
   assign bus.out_byte     = state_q == LEN_LO ? {2'b00, len_q} : state_q == BODY ? sr_q[287:280] : 8'h00;
   assign bus.out_start    = valid_q && first_q;
   assign bus.out_end      = valid_q && last;
   assign bus.err_bad_type = err_q;
   assign bus.msg_count    = msg_count_q;
endmodule

// File: tb/tb_itch_message_encoder.sv
// tb_itch_message_encoder: scoreboard bench for the ITCH encoder with and without length prefix
module tb_itch_message_encoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic out_ready = 1'b1;
   logic v0 = 1'b0, v1 = 1'b0;
   logic [7:0]  c_type = 8'h00;
   logic [15:0] c_loc = '0, c_trk = '0;
   logic [47:0] c_ts = '0;
   logic [63:0] c_ref = '0, c_new = '0, c_stk = '0;
   logic        c_bs = 1'b0;
   logic [31:0] c_sh = '0, c_px = '0;
   int errors = 0, checks = 0;
   int cyc = 0, end_cyc0 = 0, gap0 = -1;
   logic [9:0] q0[$], q1[$];
   logic [7:0] img[$];
   logic act0 = 1'b0, act1 = 1'b0;
   itch_message_encoder_if b0 ();
   itch_message_encoder_if b1 ();
   itch_message_encoder #(.EMIT_LEN_PREFIX(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   itch_message_encoder #(.EMIT_LEN_PREFIX(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   assign b0.cmd_valid = v0;
   assign b1.cmd_valid = v1;
   assign b0.out_ready = out_ready;
   assign b1.out_ready = out_ready;
   assign b0.cmd_type = c_type;      assign b1.cmd_type = c_type;
   assign b0.cmd_locate = c_loc;     assign b1.cmd_locate = c_loc;
   assign b0.cmd_tracking = c_trk;   assign b1.cmd_tracking = c_trk;
   assign b0.cmd_timestamp = c_ts;   assign b1.cmd_timestamp = c_ts;
   assign b0.cmd_order_ref = c_ref;  assign b1.cmd_order_ref = c_ref;
   assign b0.cmd_new_ref = c_new;    assign b1.cmd_new_ref = c_new;
   assign b0.cmd_buy_sell = c_bs;    assign b1.cmd_buy_sell = c_bs;
   assign b0.cmd_shares = c_sh;      assign b1.cmd_shares = c_sh;
   assign b0.cmd_price = c_px;       assign b1.cmd_price = c_px;
   assign b0.cmd_stock = c_stk;      assign b1.cmd_stock = c_stk;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) img.push_back(v[8*i +: 8]);
   endtask

   task automatic expect_msg(input int d, input bit pfx);
      int n;
      img.delete();
      put(64'(c_type), 1); put(64'(c_loc), 2); put(64'(c_trk), 2); put(64'(c_ts), 6); put(c_ref, 8);
      case (c_type)
         8'h41: begin put(c_bs ? 64'h42 : 64'h53, 1); put(64'(c_sh), 4); put(c_stk, 8); put(64'(c_px), 4); end
         8'h58: put(64'(c_sh), 4);
         8'h55: begin put(c_new, 8); put(64'(c_sh), 4); put(64'(c_px), 4); end
         default: ;
      endcase
      n = img.size();
      if (pfx) begin
         img.push_front(8'(n));
         img.push_front(8'h00);
      end
      for (int i = 0; i < img.size(); i++) begin
         if (d == 0) q0.push_back({i == 0, i == img.size() - 1, img[i]});
         else q1.push_back({i == 0, i == img.size() - 1, img[i]});
      end
   endtask

   task automatic set_cmd(input logic [7:0] t, input logic [63:0] r, input logic [63:0] nr,
                          input logic bs, input logic [31:0] sh, input logic [31:0] px, input logic [63:0] stk);
      c_type = t; c_ref = r; c_new = nr; c_bs = bs; c_sh = sh; c_px = px; c_stk = stk;
      c_loc = 16'h1234 + 16'(t); c_trk = 16'h0001 + 16'(cyc); c_ts = 48'h0000_1234_5678 + 48'(cyc);
   endtask

   task automatic send(input int d, input bit pfx, input bit good);
      int i;
      if (good) expect_msg(d, pfx);
      if (d == 0) v0 = 1'b1; else v1 = 1'b1;
      for (i = 0; i < 500; i++) begin
         @(negedge clk);
         if ((d == 0) ? b0.cmd_ready : b1.cmd_ready) break;
      end
      chk("accept_timeout", 64'(i >= 500), 64'd0);
      @(posedge clk); #1;
      v0 = 1'b0; v1 = 1'b0;
      c_ref = ~c_ref; c_new = ~c_new; c_sh = ~c_sh; c_px = ~c_px; c_stk = ~c_stk; c_bs = ~c_bs; c_ts = ~c_ts;
   endtask

   task automatic drain(input int d, input bit tog);
      int n;
      for (n = 0; n < 2000; n++) begin
         if ((d == 0 ? q0.size() : q1.size()) == 0) break;
         @(posedge clk); #1;
         if (tog) out_ready = ~out_ready;
      end
      chk("drain_timeout", 64'(n >= 2000), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
   endtask

   // Scoreboard for the unprefixed encoder: compares every presented byte, pops on acceptance
   always @(negedge clk) begin
      if (rst_n) begin
         if (act0) chk("hold_valid0", 64'(b0.out_valid), 64'd1);
         if (b0.out_valid) begin
            if (q0.size() == 0) chk("unexpected0", 64'(b0.out_valid), 64'd0);
            else begin
               chk(b0.out_ready ? "byte0" : "stall0", 64'({b0.out_start, b0.out_end, b0.out_byte}), 64'(q0[0]));
               if (b0.out_ready) begin
                  if (b0.out_start) gap0 = cyc - end_cyc0;
                  if (b0.out_end) end_cyc0 = cyc;
                  void'(q0.pop_front());
                  act0 = q0.size() != 0 && !b0.out_end;
               end
            end
         end
      end else act0 = 1'b0;
   end

   // Scoreboard for the prefixed encoder
   always @(negedge clk) begin
      if (rst_n) begin
         if (act1) chk("hold_valid1", 64'(b1.out_valid), 64'd1);
         if (b1.out_valid) begin
            if (q1.size() == 0) chk("unexpected1", 64'(b1.out_valid), 64'd0);
            else begin
               chk(b1.out_ready ? "byte1" : "stall1", 64'({b1.out_start, b1.out_end, b1.out_byte}), 64'(q1[0]));
               if (b1.out_ready) begin
                  void'(q1.pop_front());
                  act1 = q1.size() != 0 && !b1.out_end;
               end
            end
         end
      end else act1 = 1'b0;
   end

   initial begin
      #3;
      chk("rst_cmd_ready", 64'(b0.cmd_ready), 64'd0);
      chk("rst_out_valid", 64'(b0.out_valid), 64'd0);
      chk("rst_msg_count", 64'(b0.msg_count), 64'd0);
      chk("rst_err", 64'(b1.err_bad_type), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", 64'(b0.cmd_ready), 64'd1);
      set_cmd(8'h41, 64'h1, 64'h0, 1'b1, 32'd100, 32'h0016E360, "AAPL    ");
      send(0, 1'b0, 1'b1);
      chk("a_lat_valid", 64'(b0.out_valid), 64'd1);
      chk("a_lat_start", 64'(b0.out_start), 64'd1);
      chk("a_lat_byte", 64'(b0.out_byte), 64'h41);
      chk("a_busy_ready", 64'(b0.cmd_ready), 64'd0);
      drain(0, 1'b0);
      chk("a_count", 64'(b0.msg_count), 64'd1);
      set_cmd(8'h44, 64'hDEADBEEF00000000, 64'h0, 1'b0, 32'h0, 32'h0, 64'h0);
      send(1, 1'b1, 1'b1);
      chk("d_lat_byte", 64'(b1.out_byte), 64'h00);
      drain(1, 1'b0);
      chk("d_count", 64'(b1.msg_count), 64'd1);
      set_cmd(8'h55, 64'h0102030405060708, 64'hA1B2C3D4E5F60718, 1'b0, 32'h00001388, 32'h7FFF0001, 64'h0);
      send(0, 1'b0, 1'b1);
      drain(0, 1'b1);
      chk("u_count", 64'(b0.msg_count), 64'd2);
      set_cmd(8'h5A, 64'h55, 64'h0, 1'b1, 32'd1, 32'd1, 64'h0);
      send(0, 1'b0, 1'b0);
      chk("z_err", 64'(b0.err_bad_type), 64'd1);
      chk("z_valid", 64'(b0.out_valid), 64'd0);
      @(posedge clk); #1;
      chk("z_err_pulse", 64'(b0.err_bad_type), 64'd0);
      chk("z_count", 64'(b0.msg_count), 64'd2);
      chk("z_ready", 64'(b0.cmd_ready), 64'd1);
      set_cmd(8'h58, 64'hCAFEF00D12345678, 64'h0, 1'b0, 32'd250, 32'h0, 64'h0);
      send(0, 1'b0, 1'b1);
      chk("x_busy_ready", 64'(b0.cmd_ready), 64'd0);
      set_cmd(8'h41, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0, 32'hFFFFFFFF, 32'h80000000, "MSFT    ");
      send(0, 1'b0, 1'b1);
      drain(0, 1'b0);
      chk("xa_gap", 64'(gap0), 64'd2);
      chk("xa_count", 64'(b0.msg_count), 64'd4);
      set_cmd(8'h41, 64'h1122334455667788, 64'h0, 1'b1, 32'd7, 32'd9, "IBM     ");
      send(0, 1'b0, 1'b1);
      for (int i = 0; i < 100 && q0.size() > 26; i++) begin
         @(posedge clk); #1;
      end
      chk("rst_mid_pos", 64'(q0.size()), 64'd26);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 64'(b0.out_valid), 64'd0);
      chk("rst_mid_start", 64'(b0.out_start), 64'd0);
      chk("rst_mid_byte", 64'(b0.out_byte), 64'd0);
      chk("rst_mid_count", 64'(b0.msg_count), 64'd0);
      chk("rst_mid_ready", 64'(b0.cmd_ready), 64'd0);
      q0.delete();
      q1.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      set_cmd(8'h58, 64'h0000000000ABCDEF, 64'h0, 1'b0, 32'd42, 32'h0, 64'h0);
      send(0, 1'b0, 1'b1);
      chk("x2_lat_byte", 64'(b0.out_byte), 64'h58);
      drain(0, 1'b0);
      chk("x2_count", 64'(b0.msg_count), 64'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
